// File: rtl/lcd_bus_driver.sv
// rtl/lcd_bus_driver.sv - HD44780 write-only bus timing engine for the DE2 character LCD
//
// Turns one byte-write request (valid/ready handshake) into a complete LCD
// bus cycle. The sequence is RS/DATA setup, an EN strobe, hold, and then a
// fixed controller execution wait. Busy-flag reads are not used.
//
// Ports:
//   clk        system clock (CLOCK_50)
//   rst        asynchronous active-high reset
//   req_valid  request present
//   req_ready  idle and able to accept
//   req_rs     0 = instruction, 1 = data
//   req_data   byte to write
//   busy       inverse of req_ready
//   lcd_data   LCD data bus (latched on accept)
//   lcd_rs     LCD register select (latched on accept)
//   lcd_rw     LCD read/write, tied low
//   lcd_en     LCD enable strobe, straight from a flop

module lcd_bus_driver #(
   parameter int T_SETUP     = 3,
   parameter int T_EN_HIGH   = 12,
   parameter int T_HOLD      = 1,
   parameter int T_EXEC      = 2000,
   parameter int T_EXEC_LONG = 82000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rs,
   input  logic [7:0] req_data,
   output logic       busy,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en
);

   localparam int CW = $clog2(T_EXEC_LONG + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      PULSE = 3'd2,
      HOLD  = 3'd3,
      WAIT  = 3'd4
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic          cnt_zero;
   logic          long_sel;
   logic          accept;
   logic          req_long;

   assign cnt_zero = (cnt == '0);
   assign accept   = req_valid && (state == IDLE);

   // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
   assign req_long = !req_rs && (req_data == 8'h01 || req_data == 8'h02 || req_data == 8'h03);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid) state_nxt = SETUP;
         SETUP:   if (cnt_zero)  state_nxt = PULSE;
         PULSE:   if (cnt_zero)  state_nxt = HOLD;
         HOLD:    if (cnt_zero)  state_nxt = WAIT;
         WAIT:    if (cnt_zero)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      req_ready = (state == IDLE);
      busy      = (state != IDLE);
   end

   assign lcd_rw = 1'b0;

   // Counter and bus registers. lcd_en is set and cleared on the same edges
   // that move the FSM into and out of PULSE, so it stays glitch-free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         lcd_en   <= 1'b0;
         lcd_data <= 8'h00;
         lcd_rs   <= 1'b0;
         long_sel <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  lcd_rs   <= req_rs;
                  lcd_data <= req_data;
                  long_sel <= req_long;
                  cnt      <= CW'(T_SETUP - 1);
               end
            end
            SETUP: begin
               if (cnt_zero) begin
                  cnt    <= CW'(T_EN_HIGH - 1);
                  lcd_en <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            PULSE: begin
               if (cnt_zero) begin
                  cnt    <= CW'(T_HOLD - 1);
                  lcd_en <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HOLD: begin
               if (cnt_zero) begin
                  cnt <= long_sel ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            WAIT: begin
               if (!cnt_zero) begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               cnt    <= '0;
               lcd_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// tb/tb_lcd_bus_driver.sv - self-checking bench for lcd_bus_driver

module tb_lcd_bus_driver;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic       req_rs;
   logic [7:0] req_data;
   logic       busy;
   logic [7:0] lcd_data;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_en;

   int checks = 0;
   int errors = 0;

   lcd_bus_driver #(
      .T_SETUP(2), .T_EN_HIGH(3), .T_HOLD(1), .T_EXEC(5), .T_EXEC_LONG(20)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_rs(req_rs), .req_data(req_data), .busy(busy),
      .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rs;
      logic [7:0] data;
      int         exp_ready;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Issue one request from a negedge with req_ready=1. Cycle k is sampled at
   // the negedge following accept edge N + k - 1. Returns when req_ready is
   // seen again, or after a bounded number of cycles (ready_cyc = -1).
   task automatic run_req(input logic rs, input logic [7:0] data,
                          output int ready_cyc, output int en_first, output int en_last,
                          output int en_rises, output int d1, output int rs1, output int rdy1);
      logic prev_en;
      req_rs    = rs;
      req_data  = data;
      req_valid = 1'b1;
      ready_cyc = -1;
      en_first  = -1;
      en_last   = -1;
      en_rises  = 0;
      d1        = -1;
      rs1       = -1;
      rdy1      = -1;
      prev_en   = 1'b0;
      @(posedge clk);
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 1) begin
            d1        = lcd_data;
            rs1       = lcd_rs;
            rdy1      = req_ready;
            req_valid = 1'b0;
         end
         if (lcd_en) begin
            if (en_first < 0) en_first = k;
            en_last = k;
            if (!prev_en) en_rises++;
         end
         prev_en = lcd_en;
         if (req_ready) begin
            ready_cyc = k;
            break;
         end
      end
   endtask

   int rc, ef, el, er, d1, rs1, rdy1;
   int en_bits;
   int rises;
   int rdy_first;
   int rdy_second;
   logic prev;

   initial begin
      vecs[0] = '{1'b1, 8'h41, 12};
      vecs[1] = '{1'b0, 8'h01, 27};
      vecs[2] = '{1'b0, 8'h02, 27};
      vecs[3] = '{1'b0, 8'h03, 27};
      vecs[4] = '{1'b0, 8'h80, 12};
      vecs[5] = '{1'b1, 8'h01, 12};
      vecs[6] = '{1'b0, 8'h04, 12};

      rst       = 1'b0;
      req_valid = 1'b0;
      req_rs    = 1'b0;
      req_data  = 8'h00;

      // Reset asserted mid-cycle, outputs must clear at once
      #3 rst = 1'b1;
      #1;
      chk("reset lcd_en", lcd_en, 0);
      chk("reset lcd_rs", lcd_rs, 0);
      chk("reset lcd_rw", lcd_rw, 0);
      chk("reset lcd_data", lcd_data, 8'h00);
      chk("reset req_ready", req_ready, 1);
      chk("reset busy", busy, 0);

      // No accept while in reset even with a request present
      req_valid = 1'b1;
      req_rs    = 1'b1;
      req_data  = 8'h5A;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset no accept data", lcd_data, 8'h00);
      chk("reset no accept ready", req_ready, 1);
      chk("reset no accept en", lcd_en, 0);
      req_valid = 1'b0;
      rst       = 1'b0;
      @(negedge clk);

      // Table of single requests
      for (int i = 0; i < 7; i++) begin
         run_req(vecs[i].rs, vecs[i].data, rc, ef, el, er, d1, rs1, rdy1);
         chk($sformatf("vec%0d ready cycle", i), rc, vecs[i].exp_ready);
         chk($sformatf("vec%0d en first", i), ef, 3);
         chk($sformatf("vec%0d en last", i), el, 5);
         chk($sformatf("vec%0d en rises", i), er, 1);
         chk($sformatf("vec%0d lcd_data", i), d1, int'(vecs[i].data));
         chk($sformatf("vec%0d lcd_rs", i), rs1, int'(vecs[i].rs));
         chk($sformatf("vec%0d ready after accept", i), rdy1, 0);
         chk($sformatf("vec%0d lcd_rw", i), lcd_rw, 0);
         chk($sformatf("vec%0d data kept idle", i), lcd_data, int'(vecs[i].data));
      end

      // Back-to-back with req_valid held: 0x38 then 0x0C
      req_rs     = 1'b0;
      req_data   = 8'h38;
      req_valid  = 1'b1;
      en_bits    = 0;
      rises      = 0;
      rdy_first  = -1;
      rdy_second = -1;
      prev       = 1'b0;
      @(posedge clk);
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (lcd_en) en_bits |= (1 << k);
         if (lcd_en && !prev) rises++;
         prev = lcd_en;
         if (k == 1) req_data = 8'h0C;
         if (k <= 12) chk($sformatf("b2b first data k%0d", k), lcd_data, 8'h38);
         if (k == 13) begin
            chk("b2b second data", lcd_data, 8'h0C);
            chk("b2b second accepted", req_ready, 0);
            req_valid = 1'b0;
         end
         if (req_ready && rdy_first < 0) rdy_first = k;
         else if (req_ready && k > 12) begin
            rdy_second = k;
            break;
         end
      end
      chk("b2b first ready", rdy_first, 12);
      chk("b2b second ready", rdy_second, 24);
      chk("b2b en pattern", en_bits, (7 << 3) | (7 << 15));
      chk("b2b en rises", rises, 2);

      // Busy ignore: data change during PULSE must not reach the bus
      req_rs    = 1'b1;
      req_data  = 8'h41;
      req_valid = 1'b1;
      rises     = 0;
      prev      = 1'b0;
      @(posedge clk);
      for (int k = 1; k <= 13; k++) begin
         @(negedge clk);
         if (k == 1) req_valid = 1'b0;
         if (k == 3) begin
            chk("ignore in pulse", lcd_en, 1);
            req_data  = 8'hFF;
            req_valid = 1'b1;
         end
         if (lcd_en && !prev && k <= 12) rises++;
         prev = lcd_en;
         if (k <= 12) chk($sformatf("ignore data k%0d", k), lcd_data, 8'h41);
         if (k == 13) begin
            chk("ignore next accept data", lcd_data, 8'hFF);
            req_valid = 1'b0;
         end
      end
      chk("ignore en rises", rises, 1);
      rc = -1;
      for (int k = 14; k <= 40; k++) begin
         @(negedge clk);
         if (req_ready) begin
            rc = k;
            break;
         end
      end
      chk("ignore drain ready", rc, 24);

      // Abort during PULSE
      req_rs    = 1'b1;
      req_data  = 8'h33;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort en before", lcd_en, 1);
      #2 rst = 1'b1;
      #1;
      chk("abort en cleared", lcd_en, 0);
      chk("abort ready", req_ready, 1);
      chk("abort data cleared", lcd_data, 8'h00);
      @(negedge clk);
      rst   = 1'b0;
      rises = 0;
      rc    = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (lcd_en) rises++;
         if (!req_ready) rc++;
      end
      chk("abort no en after", rises, 0);
      chk("abort stays idle", rc, 0);

      run_req(1'b0, 8'h06, rc, ef, el, er, d1, rs1, rdy1);
      chk("post abort ready", rc, 12);
      chk("post abort en first", ef, 3);
      chk("post abort en rises", er, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_bus_driver.md
# lcd_bus_driver

Peripheral-side timing engine for the character LCD port of the single-cycle SoC on the DE2 board. It accepts one byte-write request at a time from the CPU-side I/O logic through a valid/ready handshake and turns it into an HD44780-compliant bus cycle: RS/DATA setup, an EN strobe, hold, then the controller execution wait. Its outputs drive LCD_DATA/LCD_RS/LCD_RW/LCD_EN at the top-level wrapper. Write-only: busy-flag reads are replaced by fixed execution delays.

## Interface
- T_SETUP, default 3: cycles RS/DATA are stable before EN rises (60 ns at 50 MHz); must be ≥1
- T_EN_HIGH, default 12: cycles EN is high (240 ns); must be ≥1
- T_HOLD, default 1: cycles RS/DATA are held after EN falls; must be ≥1
- T_EXEC, default 2000: execution wait for normal commands and data (40 µs); must be ≥1
- T_EXEC_LONG, default 82000: execution wait for clear/home commands (1.64 ms); must be ≥ T_EXEC
- clk  in  1  system clock (CLOCK_50)
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block idle and able to accept
- req_rs  in  1  0 = instruction, 1 = data
- req_data  in  8  byte to write
- busy  out  1  equal to ~req_ready
- lcd_data  out  8  LCD data bus
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write; always 0
- lcd_en  out  1  LCD enable strobe, driven directly from a flop

## Operation
- States: IDLE, SETUP, PULSE, HOLD, WAIT. One down-counter, sized to hold T_EXEC_LONG.
- req_ready = (state == IDLE). Accept happens on a rising clk edge where req_valid && req_ready and rst is low. On accept, latch req_rs/req_data into lcd_rs/lcd_data, select the wait length, load the counter with T_SETUP-1, and go to SETUP.
- Long-wait select: req_rs == 0 and req_data ∈ {0x01, 0x02, 0x03} (clear display, return home) uses T_EXEC_LONG. Every other request uses T_EXEC, including rs=1 with data 0x01.
- SETUP → PULSE when the counter reaches 0. Load T_EN_HIGH-1 and set lcd_en=1.
- PULSE → HOLD when the counter reaches 0. Clear lcd_en and load T_HOLD-1.
- HOLD → WAIT when the counter reaches 0. Load the selected wait minus 1.
- WAIT → IDLE when the counter reaches 0.
- lcd_data and lcd_rs change only on accept. They keep the last written value while idle.
- req_valid while not ready is ignored. Latched values are not disturbed and no request is queued.
- Reset, including mid-transaction: state=IDLE, counter=0, lcd_en=0, lcd_data=0x00, lcd_rs=0, lcd_rw=0. req_ready reads 1 during reset, but no accept occurs while rst is high. An aborted transfer is never resumed.

## Timing
- Accept edge = edge N. From cycle N+1: req_ready=0 and lcd_rs/lcd_data hold the new value.
- lcd_en is high for cycles N+1+T_SETUP through N+T_SETUP+T_EN_HIGH, exactly T_EN_HIGH cycles.
- req_ready returns to 1 at cycle N+1+L, where L = T_SETUP+T_EN_HIGH+T_HOLD+wait.
- Back-to-back: a held req_valid is accepted on the first edge where req_ready=1. There are no extra idle cycles.
- lcd_en never glitches. It has exactly one rising edge per accepted request.

## Test plan
Bench parameters: T_SETUP=2, T_EN_HIGH=3, T_HOLD=1, T_EXEC=5, T_EXEC_LONG=20.
- Reset values: assert rst asynchronously mid-cycle -> lcd_en, lcd_rs, lcd_rw = 0, lcd_data=0x00, req_ready=1 immediately. No accept while rst=1 even with req_valid=1.
- Data write: accept rs=1, data=0x41 at edge N -> lcd_data=0x41 and lcd_rs=1 from N+1. lcd_en=1 during N+3..N+5 only. req_ready=1 at N+12.
- Long command: rs=0, data=0x01 -> req_ready at N+27. Repeat with 0x02 -> N+27. rs=0, 0x80 -> N+12. rs=1, 0x01 -> N+12.
- Back-to-back with req_valid held: 0x38 then 0x0C (rs=0) -> second accept at N+12. Second EN pulse during N+15..N+17. lcd_en low between the two pulses.
- Busy ignore: change req_data to 0xFF with req_valid=1 during PULSE of a 0x41 write -> lcd_data stays 0x41 until the next accept. Exactly one EN pulse in that window.
- Abort: assert rst during PULSE -> lcd_en=0 in the same cycle. After release, req_ready=1 and no EN pulse occurs until a new request is accepted.
